bcd_to_binary_converter: RTL
============================

BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

Interface
REQ-001 SHALL have parameter: BINARY_DATA_SIZE, default 10, output binary width N; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: bcd_data  input  12  three packed BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-005 SHALL have port: start_conversion  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: binary_data  output  N  registered result; holds last value until next completion.
REQ-007 SHALL have port: conversion_complete  output  1  high for exactly one cycle per accepted request.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port: invalid_digit  output  1  registered; set when any accepted digit > 9.
REQ-010 SHALL have port: overflow  output  1  registered; set when decimal value > 2^N-1.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-012 SHALL, in IDLE with start_conversion=1 at edge E0 and all digits <= 9, latch {bcd_data, N zero bits} into a (12+N)-bit shift register, clear iteration counter, enter SHIFT.
REQ-013 SHALL, in IDLE with start_conversion=1 at E0 and any digit > 9, enter DONE directly: binary_data=0, invalid_digit=1, overflow=0.
REQ-014 SHALL, per SHIFT edge: shift whole register right 1 bit, then for each 4-bit BCD field of the shifted value subtract 3 if field >= 8; increment counter.
REQ-015 SHALL perform exactly N iterations at edges E1..EN; at EN load binary_data = register[N-1:0], overflow = (register BCD field != 0), invalid_digit = 0, enter DONE.
REQ-016 SHALL, on overflow, present the low N bits of the true value (value mod 2^N).
REQ-017 SHALL assert conversion_complete only while in DONE (one cycle), then return to IDLE at next edge.
REQ-018 SHALL ignore start_conversion in SHIFT and DONE; no queuing.
REQ-019 SHALL ignore bcd_data changes after E0 until next accepted request.
REQ-020 SHALL accept a new request on the first IDLE cycle after DONE (back-to-back throughput N+2 cycles).
REQ-021 SHALL keep binary_data, invalid_digit, overflow stable except at completion or reset.

Reset
REQ-022 SHALL, on reset_n low (any time, incl. mid-conversion), immediately force state IDLE, counter 0, shift register 0, binary_data 0, conversion_complete 0, busy 0, invalid_digit 0, overflow 0.
REQ-023 SHALL abandon any in-progress conversion on reset without asserting conversion_complete; first request after reset_n rises is accepted normally.

Verification (N=10 unless stated)
REQ-024 bcd_data=12'h999, start 1 cycle -> busy for 11 cycles, conversion_complete pulse 11 cycles after start edge, binary_data=10'd999, flags 0.
REQ-025 bcd_data=12'h255 then 12'h000 back-to-back on first IDLE cycle -> results 255 then 0, two distinct one-cycle pulses.
REQ-026 bcd_data=12'h1A3 start -> DONE next cycle, invalid_digit=1, binary_data=0, pulse 1 cycle after start edge.
REQ-027 start re-asserted and bcd_data changed during SHIFT -> ignored; result reflects original latched value.
REQ-028 reset_n low at iteration 5 of 12'h999 -> all outputs 0 asynchronously, no pulse; after release, 12'h042 -> binary_data=42.
REQ-029 N=8: bcd_data=12'h256 -> binary_data=8'd0, overflow=1; 12'h255 -> 8'd255, overflow=0.

Source files
------------

// File: rtl/bcd_to_binary_converter.sv
// Three-digit packed BCD to N-bit binary converter using the shift-right
// (reverse double-dabble) algorithm, one bit per clock.
module bcd_to_binary_converter #(
  parameter int BINARY_DATA_SIZE = 10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [11:0]                 bcd_data,
  input  logic                        start_conversion,
  output logic [BINARY_DATA_SIZE-1:0] binary_data,
  output logic                        conversion_complete,
  output logic                        busy,
  output logic                        invalid_digit,
  output logic                        overflow
);

  localparam int N    = BINARY_DATA_SIZE;
  localparam int SR_W = 12 + N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [SR_W-1:0] shift_reg;
  logic [SR_W-1:0] shifted;
  logic [SR_W-1:0] corrected;
  logic [4:0]      iter_count;
  logic            digits_valid;
  logic            last_iter;

  assign digits_valid = (bcd_data[11:8] <= 4'd9) &&
                        (bcd_data[7:4]  <= 4'd9) &&
                        (bcd_data[3:0]  <= 4'd9);

  assign last_iter = (iter_count == 5'(N - 1));

  // A digit of 8 or more after the shift holds a half-ten (5) borrowed from
  // the digit above; taking 3 off turns that binary weight back into BCD.
  always_comb begin
    shifted   = shift_reg >> 1;
    corrected = shifted;
    for (int d = 0; d < 3; d++) begin
      if (shifted[N + 4*d +: 4] >= 4'd8) begin
        corrected[N + 4*d +: 4] = shifted[N + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_conversion) begin
          next_state = digits_valid ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    conversion_complete = (state == DONE);
    busy                = (state != IDLE);
  end

  // Whatever remains in the BCD field after N shifts is value >> N, so any
  // nonzero residue means the result did not fit in N bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg     <= '0;
      iter_count    <= '0;
      binary_data   <= '0;
      invalid_digit <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_conversion) begin
            if (digits_valid) begin
              shift_reg  <= {bcd_data, {N{1'b0}}};
              iter_count <= '0;
            end else begin
              binary_data   <= '0;
              invalid_digit <= 1'b1;
              overflow      <= 1'b0;
            end
          end
        end
        SHIFT: begin
          shift_reg  <= corrected;
          iter_count <= iter_count + 5'd1;
          if (last_iter) begin
            binary_data   <= corrected[N-1:0];
            overflow      <= |corrected[SR_W-1:N];
            invalid_digit <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
